// File: rtl/prestep_pkg.sv
// Shared widths, word layouts and FSM encoding for the contact pre-step scheduler.
package prestep_pkg;

    localparam int unsigned POS_W  = 31;
    localparam int unsigned NORM_W = 22;
    localparam int unsigned MASS_W = 29;
    localparam int unsigned BIAS_W = 31;

    // Contact word, LSB first: pen, pos_x, pos_y, norm_x, norm_y (body indices sit above)
    localparam int unsigned C_PEN_LSB   = 0;
    localparam int unsigned C_POSX_LSB  = C_PEN_LSB + POS_W;
    localparam int unsigned C_POSY_LSB  = C_POSX_LSB + POS_W;
    localparam int unsigned C_NORMX_LSB = C_POSY_LSB + POS_W;
    localparam int unsigned C_NORMY_LSB = C_NORMX_LSB + NORM_W;
    localparam int unsigned C_FIELDS_W  = C_NORMY_LSB + NORM_W;

    // Body word, LSB first: pos_x, pos_y, inv_mass, inv_I
    localparam int unsigned B_POSX_LSB = 0;
    localparam int unsigned B_POSY_LSB = B_POSX_LSB + POS_W;
    localparam int unsigned B_MASS_LSB = B_POSY_LSB + POS_W;
    localparam int unsigned B_INVI_LSB = B_MASS_LSB + NORM_W;
    localparam int unsigned BODY_REC_W = B_INVI_LSB + NORM_W;

    // Result word, LSB first: mass_norm, mass_tang, bias
    localparam int unsigned R_MNORM_LSB = 0;
    localparam int unsigned R_MTANG_LSB = R_MNORM_LSB + MASS_W;
    localparam int unsigned R_BIAS_LSB  = R_MTANG_LSB + MASS_W;
    localparam int unsigned RES_W       = R_BIAS_LSB + BIAS_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_C,
        ST_WAIT_C,
        ST_WAIT_B,
        ST_LAUNCH,
        ST_RUN,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/prestep_watchdog.sv
// Per-contact stall counter: cleared on launch, counts RUN cycles, flags the last allowed one.
module prestep_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned     CW    = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/prestep_scheduler.sv
// Batch controller time-sharing one contact pre-step engine across a contact list.
module prestep_scheduler
    import prestep_pkg::*;
#(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned BODY_W  = 5,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ADDR_W:0]                num_contacts,
    output logic [ADDR_W-1:0]              c_addr,
    input  logic [C_FIELDS_W+2*BODY_W-1:0] c_rdata,
    output logic [BODY_W-1:0]              b1_addr,
    output logic [BODY_W-1:0]              b2_addr,
    input  logic [BODY_REC_W-1:0]          b1_rdata,
    input  logic [BODY_REC_W-1:0]          b2_rdata,
    output logic                           eng_start,
    output logic [C_FIELDS_W-1:0]          eng_c,
    output logic [BODY_REC_W-1:0]          eng_b1,
    output logic [BODY_REC_W-1:0]          eng_b2,
    input  logic                           eng_done,
    input  logic [MASS_W-1:0]              eng_mass_norm,
    input  logic [MASS_W-1:0]              eng_mass_tang,
    input  logic [BIAS_W-1:0]              eng_bias,
    output logic                           res_we,
    output logic [ADDR_W-1:0]              res_addr,
    output logic [RES_W-1:0]               res_wdata,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [ADDR_W-1:0]              err_idx
);

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W:0]     count;
    logic                last;
    logic                wd_clr, wd_en, wd_expired;

    assign last = (({1'b0, idx} + (ADDR_W+1)'(1)) == count);

    prestep_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (start) state_nx = (num_contacts == '0) ? ST_DONE : ST_FETCH_C;
            ST_FETCH_C: state_nx = ST_WAIT_C;
            ST_WAIT_C:  state_nx = ST_WAIT_B;
            ST_WAIT_B:  state_nx = ST_LAUNCH;
            ST_LAUNCH:  state_nx = ST_RUN;
            // a result arriving on the watchdog's final cycle is still accepted
            ST_RUN:     if (eng_done) state_nx = ST_WRITE;
                        else if (wd_expired) state_nx = ST_DONE;
            ST_WRITE:   state_nx = last ? ST_DONE : ST_FETCH_C;
            ST_DONE:    state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        c_addr    = (state == ST_FETCH_C) ? idx : '0;
        b1_addr   = (state == ST_WAIT_C) ? c_rdata[C_FIELDS_W +: BODY_W] : '0;
        b2_addr   = (state == ST_WAIT_C) ? c_rdata[C_FIELDS_W + BODY_W +: BODY_W] : '0;
        eng_start = (state == ST_LAUNCH);
        res_we    = (state == ST_WRITE);
        res_addr  = (state == ST_WRITE) ? idx : '0;
        busy      = (state != ST_IDLE) && (state != ST_DONE);
        done      = (state == ST_DONE);
        wd_clr    = (state == ST_LAUNCH);
        wd_en     = (state == ST_RUN) && !eng_done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            count     <= '0;
            eng_c     <= '0;
            eng_b1    <= '0;
            eng_b2    <= '0;
            res_wdata <= '0;
            err       <= 1'b0;
            err_idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    count <= num_contacts;
                    idx   <= '0;
                    err   <= 1'b0;
                end
                ST_WAIT_C: eng_c <= c_rdata[C_FIELDS_W-1:0];
                ST_WAIT_B: begin
                    eng_b1 <= b1_rdata;
                    eng_b2 <= b2_rdata;
                end
                ST_RUN: if (eng_done) begin
                    res_wdata[R_MNORM_LSB +: MASS_W] <= eng_mass_norm;
                    res_wdata[R_MTANG_LSB +: MASS_W] <= eng_mass_tang;
                    res_wdata[R_BIAS_LSB  +: BIAS_W] <= eng_bias;
                end else if (wd_expired) begin
                    err     <= 1'b1;
                    err_idx <= idx;
                end
                ST_WRITE: if (!last) idx <= idx + ADDR_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prestep_scheduler.sv
// Table-driven bench for prestep_scheduler with RAM and fixed-latency engine models.
module tb_prestep_scheduler;
    import prestep_pkg::*;

    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned BODY_W  = 5;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned C_W     = C_FIELDS_W + 2*BODY_W;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [ADDR_W:0]       num_contacts = '0;
    logic [ADDR_W-1:0]     c_addr;
    logic [C_W-1:0]        c_rdata;
    logic [BODY_W-1:0]     b1_addr, b2_addr;
    logic [BODY_REC_W-1:0] b1_rdata, b2_rdata;
    logic                  eng_start;
    logic [C_FIELDS_W-1:0] eng_c;
    logic [BODY_REC_W-1:0] eng_b1, eng_b2;
    logic                  eng_done;
    logic [MASS_W-1:0]     eng_mass_norm, eng_mass_tang;
    logic [BIAS_W-1:0]     eng_bias;
    logic                  res_we;
    logic [ADDR_W-1:0]     res_addr;
    logic [RES_W-1:0]      res_wdata;
    logic                  busy, done, err;
    logic [ADDR_W-1:0]     err_idx;

    prestep_scheduler #(.ADDR_W(ADDR_W), .BODY_W(BODY_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .num_contacts(num_contacts),
        .c_addr(c_addr), .c_rdata(c_rdata),
        .b1_addr(b1_addr), .b2_addr(b2_addr), .b1_rdata(b1_rdata), .b2_rdata(b2_rdata),
        .eng_start(eng_start), .eng_c(eng_c), .eng_b1(eng_b1), .eng_b2(eng_b2),
        .eng_done(eng_done), .eng_mass_norm(eng_mass_norm), .eng_mass_tang(eng_mass_tang),
        .eng_bias(eng_bias), .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata),
        .busy(busy), .done(done), .err(err), .err_idx(err_idx)
    );

    always #5 clk = ~clk;

    logic [C_W-1:0]        c_mem [2**ADDR_W];
    logic [BODY_REC_W-1:0] b_mem [2**BODY_W];

    always @(posedge clk) begin
        c_rdata  <= c_mem[c_addr];
        b1_rdata <= b_mem[b1_addr];
        b2_rdata <= b_mem[b2_addr];
    end

    function automatic logic [RES_W-1:0] eng_fn(input logic [C_FIELDS_W-1:0] c,
                                                input logic [BODY_REC_W-1:0] b1,
                                                input logic [BODY_REC_W-1:0] b2);
        logic [MASS_W-1:0] mn, mt;
        logic [BIAS_W-1:0] bias;
        mn   = c[28:0] ^ b1[104:76];
        mt   = c[121:93] ^ b2[28:0] ^ b1[56:28];
        bias = c[30:0] + b1[61:31] - b2[92:62];
        return {bias, mt, mn};
    endfunction

    // Engine model: eng_done L cycles after eng_start, result from the held operands
    int unsigned      eng_lat = 4;
    bit               eng_on = 1'b1;
    bit               spur_done = 1'b0;
    int unsigned      remain = 0;
    logic             eng_done_m = 1'b0;
    logic [RES_W-1:0] eng_res = '0;

    assign eng_done = eng_done_m | spur_done;
    assign {eng_bias, eng_mass_tang, eng_mass_norm} = eng_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            remain     <= 0;
            eng_done_m <= 1'b0;
        end else begin
            eng_done_m <= 1'b0;
            if (eng_start && eng_on) begin
                if (eng_lat == 1) begin
                    eng_done_m <= 1'b1;
                    eng_res    <= eng_fn(eng_c, eng_b1, eng_b2);
                end else begin
                    remain <= eng_lat - 1;
                end
            end else if (remain != 0) begin
                remain <= remain - 1;
                if (remain == 1) begin
                    eng_done_m <= 1'b1;
                    eng_res    <= eng_fn(eng_c, eng_b1, eng_b2);
                end
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int n;
        int lat;
        bit on;
        int exp_done;
        int exp_writes;
        int exp_starts;
        bit exp_err;
        int exp_err_idx;
        int spur_s1;
        int spur_s2;
        int spur_d;
    } vec_t;

    function automatic logic [RES_W-1:0] exp_res(input int j);
        logic [C_W-1:0]    ci;
        logic [BODY_W-1:0] i1, i2;
        ci = c_mem[j];
        i1 = ci[C_FIELDS_W +: BODY_W];
        i2 = ci[C_FIELDS_W + BODY_W +: BODY_W];
        return eng_fn(ci[C_FIELDS_W-1:0], b_mem[i1], b_mem[i2]);
    endfunction

    task automatic run_vec(input int vi, input vec_t v);
        int per, done_cyc, done_cnt, busy_bad, starts, trace_bad, j, p;
        int w_cyc[$];
        int w_addr[$];
        logic [RES_W-1:0]  w_data[$];
        logic              err_at_done;
        logic [ADDR_W-1:0] erridx_at_done;
        logic [C_W-1:0]    ci;
        logic [BODY_W-1:0] i1, i2;
        per = v.lat + 5;
        done_cyc = -1; done_cnt = 0; busy_bad = 0; starts = 0; trace_bad = 0;
        err_at_done = 1'bx; erridx_at_done = 'x;
        eng_lat = v.lat;
        eng_on  = v.on;
        @(negedge clk);
        num_contacts = (ADDR_W+1)'(v.n);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= v.exp_done + 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            spur_done = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    err_at_done = err;
                    erridx_at_done = err_idx;
                end
            end
            if (busy !== (k < v.exp_done)) busy_bad++;
            if (eng_start) starts++;
            if (res_we) begin
                w_cyc.push_back(k);
                w_addr.push_back(int'(res_addr));
                w_data.push_back(res_wdata);
            end
            j = (k - 1) / per;
            p = (k - 1) % per;
            if (k < v.exp_done && j < v.n) begin
                ci = c_mem[j];
                i1 = ci[C_FIELDS_W +: BODY_W];
                i2 = ci[C_FIELDS_W + BODY_W +: BODY_W];
                case (p)
                    0: if (c_addr !== ADDR_W'(j)) trace_bad++;
                    1: begin
                        if (b1_addr !== i1 || b2_addr !== i2) trace_bad++;
                        if (j == 0) begin
                            check($sformatf("v%0d b1_addr c0", vi), b1_addr, i1);
                            check($sformatf("v%0d b2_addr c0", vi), b2_addr, i2);
                        end
                    end
                    3: if (eng_c !== ci[C_FIELDS_W-1:0] || eng_b1 !== b_mem[i1] ||
                           eng_b2 !== b_mem[i2]) trace_bad++;
                    default: ;
                endcase
            end
            if (k == v.spur_s1 || k == v.spur_s2) start = 1'b1;
            if (k == v.spur_d) spur_done = 1'b1;
        end
        check($sformatf("v%0d done cycle", vi), done_cyc, v.exp_done);
        check($sformatf("v%0d done pulses", vi), done_cnt, 1);
        check($sformatf("v%0d busy window errors", vi), busy_bad, 0);
        check($sformatf("v%0d eng_start count", vi), starts, v.exp_starts);
        check($sformatf("v%0d trace errors", vi), trace_bad, 0);
        check($sformatf("v%0d write count", vi), w_cyc.size(), v.exp_writes);
        for (int w = 0; w < w_cyc.size() && w < v.exp_writes; w++) begin
            check($sformatf("v%0d write%0d cycle", vi, w), w_cyc[w], (w + 1) * per);
            check($sformatf("v%0d write%0d addr", vi, w), w_addr[w], w);
            check($sformatf("v%0d write%0d data", vi, w), w_data[w], exp_res(w));
        end
        check($sformatf("v%0d err at done", vi), err_at_done, v.exp_err);
        if (v.exp_err) check($sformatf("v%0d err_idx", vi), erridx_at_done, v.exp_err_idx);
        check($sformatf("v%0d err sticky", vi), err, v.exp_err);
    endtask

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL global time limit expired");
        $fatal(1, "time limit");
    end

    initial begin
        int    bad;
        vec_t  vr;
        //          n  lat on done wr st err eidx s1 s2 sd
        vecs[0] = '{3,  4, 1, 28,  3, 3, 0, 0,   0, 0, 0};
        vecs[1] = '{0,  4, 1,  1,  0, 0, 0, 0,   0, 0, 0};
        vecs[2] = '{1,  4, 1, 10,  1, 1, 0, 0,   3, 10, 2};
        vecs[3] = '{1,  8, 1, 14,  1, 1, 0, 0,   0, 0, 0};
        vecs[4] = '{2,  8, 0, 13,  0, 1, 1, 0,   0, 0, 0};
        vecs[5] = '{2,  2, 1, 15,  2, 2, 0, 0,   0, 0, 0};
        vecs[6] = '{64, 1, 1, 385, 64, 64, 0, 0, 0, 0, 0};

        for (int i = 0; i < 2**ADDR_W; i++)
            c_mem[i] = C_W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        for (int i = 0; i < 2**BODY_W; i++)
            b_mem[i] = BODY_REC_W'({$urandom(), $urandom(), $urandom(), $urandom()});
        c_mem[0][C_FIELDS_W +: BODY_W]          = BODY_W'(31);
        c_mem[0][C_FIELDS_W + BODY_W +: BODY_W] = BODY_W'(0);
        c_mem[1][C_FIELDS_W +: BODY_W]          = BODY_W'(7);
        c_mem[1][C_FIELDS_W + BODY_W +: BODY_W] = BODY_W'(19);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ctrl outputs", {busy, done, err, res_we, eng_start, res_addr, err_idx}, '0);
        check("reset data outputs", |{eng_c, eng_b1, eng_b2, res_wdata}, 1'b0);
        rst = 1'b0;

        for (int vi = 0; vi < 7; vi++) run_vec(vi, vecs[vi]);

        // Reset in the middle of RUN of an N=2 batch, then a clean rerun
        bad = 0;
        eng_lat = 4;
        eng_on  = 1'b1;
        @(negedge clk);
        num_contacts = (ADDR_W+1)'(2);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (res_we) bad++;
        end
        check("pre-reset busy in RUN", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid-run reset ctrl outputs", {busy, done, err, res_we, eng_start, c_addr,
                                             b1_addr, b2_addr, res_addr, err_idx}, '0);
        check("mid-run reset data outputs", |{eng_c, eng_b1, eng_b2, res_wdata}, 1'b0);
        repeat (3) begin
            @(negedge clk);
            if (res_we) bad++;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (res_we || busy || done) bad++;
        end
        check("mid-run reset spurious activity", bad, 0);
        vr = '{2, 4, 1, 19, 2, 2, 0, 0, 0, 0, 0};
        run_vec(7, vr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
